// File: rtl/byte_pair_pkg.sv
// Shared types for the byte pair packer: byte/word aliases and packer FSM states.
package byte_pair_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    LO_WAIT = 2'd0,
    HI_WAIT = 2'd1,
    OUT     = 2'd2
  } pack_state_e;

endpackage

// File: rtl/byte_pair_packer_if.sv
// Byte-in / word-out stream bundle; slave is the packer's view, master the driver's.
interface byte_pair_packer_if;
  import byte_pair_pkg::*;

  logic  in_valid;
  byte_t in_data;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with flush; head byte visible combinationally on rd_data.
module byte_fifo
  import byte_pair_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  byte_t            wr_data,
  input  logic             rd_en,
  output byte_t            rd_data,
  output logic [LVL_W-1:0] level
);

  byte_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/byte_pair_packer.sv
// Buffers a non-backpressured byte stream and packs byte pairs into 16-bit
// valid/ready words (first byte in [7:0]); overflow drops and counts bytes.
module byte_pair_packer
  import byte_pair_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  byte_pair_packer_if.slave  bus,
  output logic [LVL_W-1:0]   level,
  output logic               odd_pending,
  output logic [CNT_W-1:0]   overflow_cnt
);

  pack_state_e state;
  byte_t       lo;
  byte_t       rd_data;
  word_t       out_data;
  logic        out_valid;
  logic        take;
  logic        pop;
  logic        wr_en;
  logic        drop;
  logic        full;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_data (bus.in_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .level   (level)
  );

  // Pop and write gating; a pop in the same cycle frees room for a write into a full FIFO.
  always_comb begin
    take = 1'b0;
    case (state)
      LO_WAIT: take = 1'b1;
      HI_WAIT: take = 1'b1;
      OUT:     take = bus.out_ready;
      default: take = 1'b0;
    endcase
    full  = (level == LVL_W'(DEPTH));
    pop   = take && (level != '0) && !flush;
    wr_en = bus.in_valid && !flush && (!full || pop);
    drop  = bus.in_valid && !flush && full && !pop;
  end

  // Packer FSM; all outputs registered so out_valid never follows out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LO_WAIT;
      lo          <= 8'h00;
      out_data    <= 16'h0000;
      out_valid   <= 1'b0;
      odd_pending <= 1'b0;
    end else if (flush) begin
      state       <= LO_WAIT;
      lo          <= 8'h00;
      out_data    <= 16'h0000;
      out_valid   <= 1'b0;
      odd_pending <= 1'b0;
    end else begin
      case (state)
        LO_WAIT: begin
          if (pop) begin
            lo          <= rd_data;
            odd_pending <= 1'b1;
            state       <= HI_WAIT;
          end else begin
            state <= LO_WAIT;
          end
        end
        HI_WAIT: begin
          if (pop) begin
            out_data    <= {rd_data, lo};
            out_valid   <= 1'b1;
            odd_pending <= 1'b0;
            state       <= OUT;
          end else begin
            state <= HI_WAIT;
          end
        end
        OUT: begin
          if (bus.out_ready && pop) begin
            lo          <= rd_data;
            out_valid   <= 1'b0;
            odd_pending <= 1'b1;
            state       <= HI_WAIT;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= LO_WAIT;
          end else begin
            state <= OUT;
          end
        end
        default: begin
          out_valid   <= 1'b0;
          odd_pending <= 1'b0;
          state       <= LO_WAIT;
        end
      endcase
    end
  end

  // Saturating count of bytes lost to a full FIFO; flush leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != {CNT_W{1'b1}})) begin
      overflow_cnt <= overflow_cnt + CNT_W'(1);
    end else begin
      overflow_cnt <= overflow_cnt;
    end
  end

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed and random checks of byte_pair_packer against a queue-based reference model.
module tb_byte_pair_packer;
  import byte_pair_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  byte_pair_packer_if bus ();
  byte_pair_packer_if bus2 ();
  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_data   = bus.in_data;
  assign bus2.out_ready = bus.out_ready;

  logic [3:0]  level, level2;
  logic        odd, odd2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  byte_pair_packer #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave),
    .level(level), .odd_pending(odd), .overflow_cnt(cnt)
  );

  byte_pair_packer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2.slave),
    .level(level2), .odd_pending(odd2), .overflow_cnt(cnt2)
  );

  int    errors = 0;
  int    checks = 0;
  byte_t fq[$];
  byte_t held[$];
  int    drops = 0;
  word_t got_q[$];

  // Words actually handed downstream, for directed sequence checks.
  always @(posedge clk) begin
    if (rst_n && !flush && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: FIFO as a byte queue, packer as a holding list of up to two bytes.
  task automatic model_edge();
    bit acc, pop, wr;
    if (flush) begin
      fq.delete();
      held.delete();
    end else begin
      acc = (held.size() == 2) && bus.out_ready;
      pop = (fq.size() > 0) && ((held.size() < 2) || acc);
      wr  = bus.in_valid && ((fq.size() < DEPTH) || pop);
      if (bus.in_valid && !wr) drops++;
      if (acc) held.delete();
      if (pop) held.push_back(fq.pop_front());
      if (wr) fq.push_back(bus.in_data);
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = (held.size() == 2);
    check("level", 32'(level), fq.size());
    check("level_sat", 32'(level2), fq.size());
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    check("odd_pending", 32'(odd), 32'(held.size() == 1));
    check("overflow_cnt", 32'(cnt), (drops > 65535) ? 65535 : drops);
    check("overflow_cnt_sat", 32'(cnt2), (drops > 3) ? 3 : drops);
    if (ev) check("out_data", 32'(bus.out_data), {16'h0000, held[1], held[0]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;

    // Basic pair: 0x12, 0x34 -> 0x3412 valid in cycle 3
    bus.in_valid = 1'b1; bus.in_data = 8'h12; tick();
    bus.in_data = 8'h34; tick();
    bus.in_valid = 1'b0; tick();
    check("t1_valid", 32'(bus.out_valid), 32'h1);
    check("t1_data", 32'(bus.out_data), 32'h3412);
    tick();
    check("t1_done_valid", 32'(bus.out_valid), 32'h0);
    check("t1_done_level", 32'(level), 32'h0);

    // Sustained stream 0x00..0x0F with out_ready high
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i); tick();
      check("t2_level_le2", 32'(level <= 4'd2), 32'h1);
    end
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("t2_words", got_q.size(), 8);
    for (int k = 0; k < 8 && k < got_q.size(); k++)
      check("t2_word", 32'(got_q[k]), {16'h0000, 8'(2 * k + 1), 8'(2 * k)});
    check("t2_ovf", 32'(cnt), 32'h0);

    // Backpressure: 11 bytes into a stalled packer, last one dropped
    got_q.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'hA0 + 8'(i); tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("t3_level", 32'(level), 32'd8);
    check("t3_ovf", 32'(cnt), 32'd1);
    check("t3_hold", 32'(bus.out_data), 32'hA1A0);
    bus.out_ready = 1'b1;
    repeat (14) tick();
    check("t3_words", got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++)
      check("t3_word", 32'(got_q[k]), {16'h0000, 8'hA1 + 8'(2 * k), 8'hA0 + 8'(2 * k)});

    // Lone byte waits for its partner
    bus.in_valid = 1'b1; bus.in_data = 8'h55; tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_odd", 32'(odd), 32'h1);
      check("t4_novalid", 32'(bus.out_valid), 32'h0);
    end
    bus.in_valid = 1'b1; bus.in_data = 8'h66; tick();
    bus.in_valid = 1'b0; tick();
    check("t4_data", 32'(bus.out_data), 32'h6655);
    repeat (2) tick();

    // Flush with odd byte captured and three queued; flush-cycle byte not counted
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'hB0 + 8'(i); tick();
    end
    bus.in_valid = 1'b0; tick();
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0;
    check("t5_pre_odd", 32'(odd), 32'h1);
    check("t5_pre_level", 32'(level), 32'd3);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77; tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("t5_level", 32'(level), 32'h0);
    check("t5_odd", 32'(odd), 32'h0);
    check("t5_valid", 32'(bus.out_valid), 32'h0);
    check("t5_ovf", 32'(cnt), 32'd1);

    // Saturation: fill, then 12 more bytes against a full FIFO
    for (int i = 0; i < 22; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'hC0 + 8'(i); tick();
    end
    bus.in_valid = 1'b0; tick();
    check("t6_ovf", 32'(cnt), 32'd13);
    check("t6_ovf_sat", 32'(cnt2), 32'd3);
    check("t6_in_out", 32'(bus.out_valid), 32'h1);

    // Asynchronous reset while presenting a word
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_valid", 32'(bus.out_valid), 32'h0);
    check("t7_data", 32'(bus.out_data), 32'h0);
    check("t7_level", 32'(level), 32'h0);
    check("t7_odd", 32'(odd), 32'h0);
    check("t7_ovf", 32'(cnt), 32'h0);
    check("t7_ovf_sat", 32'(cnt2), 32'h0);
    fq.delete(); held.delete(); drops = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic with occasional flush; low-ready first half to force overflow
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 59) == 0);
      tick();
    end
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
